// File: rtl/simple_bus_pkg.sv
// Shared constants and helpers for the simple single-word request bus.
package simple_bus_pkg;

    localparam int RD_LATENCY_MAX = 4;

    function automatic int mem_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/simple_if.sv
// Single-word read/write request bus between one master and one slave memory.
interface simple_if #(
    parameter int ADDR_BIT_WIDTH = 2,
    parameter int DATA_BIT_WIDTH = 8
) ();

    logic [ADDR_BIT_WIDTH-1:0] addr;
    logic                      rd_req;
    logic                      wr_req;
    logic [DATA_BIT_WIDTH-1:0] wr_data;
    logic [DATA_BIT_WIDTH-1:0] rd_data;
    logic                      rd_vld;

    modport slv_port (
        input  addr, rd_req, wr_req, wr_data,
        output rd_data, rd_vld
    );

    modport mst_port (
        output addr, rd_req, wr_req, wr_data,
        input  rd_data, rd_vld
    );

endinterface

// File: rtl/rd_lat_pipe.sv
// Delays a valid/data pair by DEPTH cycles; each data stage only loads on a valid
// beat, so the output data holds the last valid word between responses.
module rd_lat_pipe #(
    parameter int DEPTH          = 0,
    parameter int DATA_BIT_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_sync_rst,
    input  logic                      i_vld,
    input  logic [DATA_BIT_WIDTH-1:0] i_data,
    output logic                      o_vld,
    output logic [DATA_BIT_WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_sync_rst;
            assign o_vld  = i_vld;
            assign o_data = i_data;
        end else begin : g_shift
            logic [DEPTH-1:0]          r_vld;
            logic [DATA_BIT_WIDTH-1:0] r_data [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_sync_rst) begin
                    r_vld <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        r_data[k] <= '0;
                    end
                end else begin
                    r_vld[0] <= i_vld;
                    if (i_vld) begin
                        r_data[0] <= i_data;
                    end
                    for (int k = 1; k < DEPTH; k++) begin
                        r_vld[k] <= r_vld[k-1];
                        if (r_vld[k-1]) begin
                            r_data[k] <= r_data[k-1];
                        end
                    end
                end
            end

            assign o_vld  = r_vld[DEPTH-1];
            assign o_data = r_data[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/slv_mem.sv
// Bus-slave memory with fixed read latency, access counters and a sticky
// protocol-error flag for simultaneous read/write requests.
module slv_mem
    import simple_bus_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 2,
    parameter int DATA_BIT_WIDTH = 8,
    parameter int RD_LATENCY     = 1,
    parameter int CNT_BIT_WIDTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_sync_rst,
    simple_if.slv_port               if_bus,
    output logic [CNT_BIT_WIDTH-1:0] o_wr_cnt,
    output logic [CNT_BIT_WIDTH-1:0] o_rd_cnt,
    output logic                     o_proto_err
);

    localparam int DEPTH = mem_depth(ADDR_BIT_WIDTH);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
            $error("slv_mem: RD_LATENCY must be within 1..RD_LATENCY_MAX");
        end
    endgenerate

    logic [DATA_BIT_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_BIT_WIDTH-1:0]  r_wr_cnt;
    logic [CNT_BIT_WIDTH-1:0]  r_rd_cnt;
    logic                      r_proto_err;
    logic                      r_rd_vld0;
    logic [DATA_BIT_WIDTH-1:0] r_rd_data0;
    logic                      w_rd_ok;
    logic                      w_wr_ok;
    logic                      w_pipe_vld;
    logic [DATA_BIT_WIDTH-1:0] w_pipe_data;

    // A read colliding with a write is dropped; the write still goes through.
    assign w_rd_ok = if_bus.rd_req & ~if_bus.wr_req;
    assign w_wr_ok = if_bus.wr_req;

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[if_bus.addr] <= if_bus.wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_cnt <= r_wr_cnt + CNT_BIT_WIDTH'(1);
            end
            if (w_rd_ok) begin
                r_rd_cnt <= r_rd_cnt + CNT_BIT_WIDTH'(1);
            end
            if (if_bus.rd_req && if_bus.wr_req) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // First read stage; the data register holds its word until the next accepted read.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_rd_vld0  <= 1'b0;
            r_rd_data0 <= '0;
        end else begin
            r_rd_vld0 <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data0 <= r_mem[if_bus.addr];
            end
        end
    end

    rd_lat_pipe #(
        .DEPTH          (RD_LATENCY - 1),
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH)
    ) u_rd_lat_pipe (
        .i_clk      (i_clk),
        .i_sync_rst (i_sync_rst),
        .i_vld      (r_rd_vld0),
        .i_data     (r_rd_data0),
        .o_vld      (w_pipe_vld),
        .o_data     (w_pipe_data)
    );

    assign if_bus.rd_vld  = w_pipe_vld;
    assign if_bus.rd_data = w_pipe_data;
    assign o_wr_cnt       = r_wr_cnt;
    assign o_rd_cnt       = r_rd_cnt;
    assign o_proto_err    = r_proto_err;

endmodule

// File: tb/tb_slv_mem.sv
// Drives two slv_mem instances (latency 1 / 16-bit counters and latency 3 / 4-bit
// counters) with the same directed bus traffic and checks both against a model.
module tb_slv_mem;

    logic       clk;
    logic       rst;
    logic       rdReq;
    logic       wrReq;
    logic [1:0] addr;
    logic [7:0] wrData;

    logic [15:0] wrCntA, rdCntA;
    logic [3:0]  wrCntB, rdCntB;
    logic        errA, errB;

    int vecCnt  = 0;
    int missCnt = 0;

    simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) busA ();
    simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) busB ();

    assign busA.addr    = addr;
    assign busA.rd_req  = rdReq;
    assign busA.wr_req  = wrReq;
    assign busA.wr_data = wrData;
    assign busB.addr    = addr;
    assign busB.rd_req  = rdReq;
    assign busB.wr_req  = wrReq;
    assign busB.wr_data = wrData;

    slv_mem #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .RD_LATENCY(1), .CNT_BIT_WIDTH(16)) dutA (
        .i_clk       (clk),
        .i_sync_rst  (rst),
        .if_bus      (busA.slv_port),
        .o_wr_cnt    (wrCntA),
        .o_rd_cnt    (rdCntA),
        .o_proto_err (errA)
    );

    slv_mem #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .RD_LATENCY(3), .CNT_BIT_WIDTH(4)) dutB (
        .i_clk       (clk),
        .i_sync_rst  (rst),
        .if_bus      (busB.slv_port),
        .o_wr_cnt    (wrCntB),
        .o_rd_cnt    (rdCntB),
        .o_proto_err (errB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: per-instance memory, plain integer counters and a
    // response schedule keyed by the edge on which each response becomes visible.
    int         lat [2] = '{1, 3};
    int         cw  [2] = '{16, 4};
    logic [7:0] mdlMem [2][4];
    int         mdlWc [2];
    int         mdlRc [2];
    bit         mdlErr [2];
    bit         schedVld [2][8];
    logic [7:0] schedData [2][8];
    bit         expVld [2];
    logic [7:0] expData [2];
    int         edgeNo = 0;
    bit         live = 0;

    task automatic modelStep();
        int slot;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int a = 0; a < 4; a++) mdlMem[i][a] = 8'h00;
                for (int s = 0; s < 8; s++) schedVld[i][s] = 1'b0;
                mdlWc[i] = 0;
                mdlRc[i] = 0;
                mdlErr[i] = 1'b0;
                expVld[i] = 1'b0;
                expData[i] = 8'h00;
            end else if (live) begin
                if (rdReq && !wrReq) begin
                    slot = (edgeNo + lat[i] - 1) % 8;
                    schedVld[i][slot] = 1'b1;
                    schedData[i][slot] = mdlMem[i][addr];
                    mdlRc[i]++;
                end
                if (wrReq) begin
                    mdlMem[i][addr] = wrData;
                    mdlWc[i]++;
                end
                if (rdReq && wrReq) mdlErr[i] = 1'b1;
                slot = edgeNo % 8;
                expVld[i] = schedVld[i][slot];
                if (schedVld[i][slot]) expData[i] = schedData[i][slot];
                schedVld[i][slot] = 1'b0;
            end
        end
        if (rst) live = 1'b1;
        edgeNo++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCnt++;
        if (act !== exp) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareStep();
        if (!live) return;
        checkOutput("vldA",  32'(busA.rd_vld),  32'(expVld[0]));
        checkOutput("dataA", 32'(busA.rd_data), 32'(expData[0]));
        checkOutput("wcntA", 32'(wrCntA), 32'(mdlWc[0] % (1 << cw[0])));
        checkOutput("rcntA", 32'(rdCntA), 32'(mdlRc[0] % (1 << cw[0])));
        checkOutput("errA",  32'(errA),   32'(mdlErr[0]));
        checkOutput("vldB",  32'(busB.rd_vld),  32'(expVld[1]));
        checkOutput("dataB", 32'(busB.rd_data), 32'(expData[1]));
        checkOutput("wcntB", 32'(wrCntB), 32'(mdlWc[1] % (1 << cw[1])));
        checkOutput("rcntB", 32'(rdCntB), 32'(mdlRc[1] % (1 << cw[1])));
        checkOutput("errB",  32'(errB),   32'(mdlErr[1]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            compareStep();
        end
    end

    // Inputs change 1 time unit after the rising edge and are sampled on the next one.
    task automatic applyStimulus(input logic r, input logic rd, input logic wr,
                                 input logic [1:0] a, input logic [7:0] d);
        rst    = r;
        rdReq  = rd;
        wrReq  = wr;
        addr   = a;
        wrData = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; rdReq = 1'b0; wrReq = 1'b0; addr = 2'd0; wrData = 8'h00;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);

        // Back-to-back reads of a freshly cleared memory.
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'(a), 8'h00);
            checkOutput("t1_vldA", 32'(busA.rd_vld), 32'd1);
            checkOutput("t1_dataA", 32'(busA.rd_data), 32'h00);
        end
        idle(4);
        checkOutput("t1_rcntA", 32'(rdCntA), 32'd4);
        checkOutput("t1_rcntB", 32'(rdCntB), 32'd4);

        // Write a ramp then read it back in order.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        for (int a = 0; a < 4; a++) applyStimulus(1'b0, 1'b0, 1'b1, 2'(a), 8'(a));
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'(a), 8'h00);
            checkOutput("t2_dataA", 32'(busA.rd_data), 32'(a));
        end
        idle(4);
        checkOutput("t2_wcntA", 32'(wrCntA), 32'd4);
        checkOutput("t2_rcntA", 32'(rdCntA), 32'd4);
        checkOutput("t2_errA",  32'(errA),   32'd0);

        // Latency-3 timing of a read that follows a write to the same word.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 8'h5A);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
        idle(1);
        checkOutput("t3_vldB_early", 32'(busB.rd_vld), 32'd0);
        idle(1);
        checkOutput("t3_vldB",  32'(busB.rd_vld),  32'd1);
        checkOutput("t3_dataB", 32'(busB.rd_data), 32'h5A);
        idle(1);
        checkOutput("t3_vldB_late", 32'(busB.rd_vld),  32'd0);
        checkOutput("t3_holdB",     32'(busB.rd_data), 32'h5A);

        // Colliding read and write: write wins, read dropped, error sticks.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 8'hA5);
        checkOutput("t4_vldA", 32'(busA.rd_vld), 32'd0);
        idle(10);
        checkOutput("t4_errA", 32'(errA), 32'd1);
        checkOutput("t4_errB", 32'(errB), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 8'h00);
        checkOutput("t4_dataA", 32'(busA.rd_data), 32'hA5);
        idle(3);
        checkOutput("t4_wcntA", 32'(wrCntA), 32'd1);
        checkOutput("t4_rcntA", 32'(rdCntA), 32'd1);

        // Reset with reads in flight flushes them and clears memory.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'h11);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 8'h22);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            checkOutput("t5_vldB",  32'(busB.rd_vld),  32'd0);
            checkOutput("t5_dataB", 32'(busB.rd_data), 32'h00);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        idle(2);
        checkOutput("t5_rdvldB",  32'(busB.rd_vld),  32'd1);
        checkOutput("t5_rddataB", 32'(busB.rd_data), 32'h00);
        idle(1);

        // Counter wrap on the 4-bit instance.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        for (int k = 0; k < 17; k++) applyStimulus(1'b0, 1'b0, 1'b1, 2'(k % 4), 8'(k));
        idle(2);
        checkOutput("t6_wcntB", 32'(wrCntB), 32'd1);
        checkOutput("t6_wcntA", 32'(wrCntA), 32'd17);
        checkOutput("t6_rcntB", 32'(rdCntB), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
